// File: rtl/game_pkg.sv
// Shared geometry and types for the flappy-bird referee and its hit-test slice.
// Coordinates are 11-bit; all geometry sums are done in 12 bits so nothing wraps.
package game_pkg;

  localparam logic [11:0] SCREEN_W = 12'd1024;
  localparam logic [11:0] TUBE_W   = 12'd120;
  localparam logic [11:0] GAP_H    = 12'd250;
  localparam logic [11:0] BIRD_W   = 12'd40;
  localparam logic [11:0] BIRD_H   = 12'd50;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {RUN, PENDING, OVER} ref_state_e;

endpackage

// File: rtl/bird_tube_hit.sv
// Per-bird tube selection and collision test for a bird column fixed at x = BX.
// The active tube is the nearest on-screen tube whose trailing edge is still ahead of the bird.
module bird_tube_hit
  import game_pkg::*;
#(
  parameter int BX      = 180,
  parameter int N_TUBES = 3,
  parameter int IDX_W   = 2
) (
  input  coord_t [N_TUBES-1:0] tube_x_i,
  input  coord_t [N_TUBES-1:0] gap_y_i,
  input  coord_t               by_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     active_idx_o,
  output logic                 active_valid_o
);

  localparam logic [11:0] BXL = 12'(BX);
  localparam logic [11:0] BXR = BXL + BIRD_W - 12'd1;

  always_comb begin
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic [11:0]      tx, gy, by, x;
    vld = 1'b0;
    idx = '0;
    tx  = '0;
    gy  = '0;
    by  = {1'b0, by_i};
    // Strict '<' keeps the lowest index when two tubes share an x.
    for (int i = 0; i < N_TUBES; i++) begin
      x = {1'b0, tube_x_i[i]};
      if (x < SCREEN_W && x + TUBE_W > BXL && (!vld || x < tx)) begin
        vld = 1'b1;
        idx = IDX_W'(i);
        tx  = x;
        gy  = {1'b0, gap_y_i[i]};
      end
    end
    active_valid_o = vld;
    active_idx_o   = idx;
    hit_o = vld && (BXR >= tx) && (BXL <= tx + TUBE_W - 12'd1) &&
            ((by < gy) || (by + BIRD_H - 12'd1 > gy + GAP_H));
  end

endmodule

// File: rtl/race_referee.sv
// N-player flappy-bird referee: alive tracking, tube scoring and winner resolution,
// with delayed resolution while the last survivor is still level with a tube that downed others.
module race_referee
  import game_pkg::*;
#(
  parameter int N_BIRDS = 4,
  parameter int N_TUBES = 3,
  parameter int SCORE_W = 8,
  parameter int BIRD_X0 = 180,
  parameter int BIRD_DX = 80
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              game_rst_i,
  input  logic                              tick_i,
  input  coord_t [N_BIRDS-1:0]              bird_y_i,
  input  logic   [N_BIRDS-1:0]              bird_edge_i,
  input  coord_t [N_TUBES-1:0]              tube_x_i,
  input  coord_t [N_TUBES-1:0]              gap_y_i,
  output logic   [N_BIRDS-1:0]              alive_o,
  output logic   [N_BIRDS-1:0][SCORE_W-1:0] score_o,
  output logic                              game_over_o,
  output logic                              winner_valid_o,
  output logic   [N_BIRDS-1:0]              winner_mask_o
);

  localparam int IDX_W = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
  localparam int CNT_W = $clog2(N_BIRDS + 1);

  function automatic logic [11:0] bx_of(int b);
    return 12'(BIRD_X0 + b * BIRD_DX);
  endfunction

  ref_state_e                        state_q;
  logic [N_BIRDS-1:0]                alive_q, alive_d;
  logic [N_BIRDS-1:0][SCORE_W-1:0]   score_q, score_d;
  coord_t [N_TUBES-1:0]              prev_q;
  logic                              pend_vld_q;
  logic [IDX_W-1:0]                  pend_tube_q;
  logic [N_BIRDS-1:0]                pend_grp_q;
  logic                              game_over_q, win_vld_q;
  logic [N_BIRDS-1:0]                win_mask_q;

  logic [N_BIRDS-1:0]                hit, act_vld, crash, tcrash, on_pend, passed, new_grp, fin_mask;
  logic [N_BIRDS-1:0][IDX_W-1:0]     act_idx;
  logic [CNT_W-1:0]                  surv;
  logic                              new_vld, fin, to_pend, load_pend;
  logic [IDX_W-1:0]                  new_tube;
  logic [11:0]                       pend_x;

  for (genvar g = 0; g < N_BIRDS; g++) begin : g_bird
    bird_tube_hit #(
      .BX      (BIRD_X0 + g * BIRD_DX),
      .N_TUBES (N_TUBES),
      .IDX_W   (IDX_W)
    ) u_hit (
      .tube_x_i       (tube_x_i),
      .gap_y_i        (gap_y_i),
      .by_i           (bird_y_i[g]),
      .hit_o          (hit[g]),
      .active_idx_o   (act_idx[g]),
      .active_valid_o (act_vld[g])
    );
  end

  always_comb begin
    logic inc;
    logic [11:0] px, tx;
    inc     = 1'b0;
    px      = '0;
    tx      = '0;
    crash   = alive_q & (bird_edge_i | hit);
    tcrash  = alive_q & hit & act_vld;
    alive_d = alive_q & ~crash;
    surv    = '0;
    for (int b = 0; b < N_BIRDS; b++) surv = surv + CNT_W'(alive_d[b]);

    // A multi-tube crash tick resolves to the tube of the lowest-index tube-crashed bird.
    new_vld  = 1'b0;
    new_tube = '0;
    for (int b = 0; b < N_BIRDS; b++)
      if (tcrash[b] && !new_vld) begin
        new_vld  = 1'b1;
        new_tube = act_idx[b];
      end
    for (int b = 0; b < N_BIRDS; b++) new_grp[b] = tcrash[b] && (act_idx[b] == new_tube);

    pend_x = {1'b0, tube_x_i[pend_tube_q]};
    for (int b = 0; b < N_BIRDS; b++) begin
      on_pend[b] = tcrash[b] && (act_idx[b] == pend_tube_q);
      passed[b]  = alive_q[b] && ((bx_of(b) >= pend_x + TUBE_W) || (pend_x >= SCREEN_W));
    end

    // Only a tube that was on-screen last tick can score, so respawns and the reset value never do.
    for (int b = 0; b < N_BIRDS; b++) begin
      inc = 1'b0;
      for (int t = 0; t < N_TUBES; t++) begin
        px = {1'b0, prev_q[t]};
        tx = {1'b0, tube_x_i[t]};
        if (px < SCREEN_W && px + TUBE_W > bx_of(b) && tx + TUBE_W <= bx_of(b)) inc = 1'b1;
      end
      score_d[b] = (alive_d[b] && inc && score_q[b] != '1) ? score_q[b] + 1'b1 : score_q[b];
    end

    fin       = 1'b0;
    fin_mask  = '0;
    to_pend   = 1'b0;
    load_pend = 1'b0;
    case (state_q)
      RUN: if (|crash) begin
        load_pend = new_vld && (surv != '0);
        if (surv == CNT_W'(1)) begin
          if (new_vld || pend_vld_q) to_pend = 1'b1;
          else begin
            fin      = 1'b1;
            fin_mask = alive_d;
          end
        end else if (surv == '0) begin
          fin      = 1'b1;
          fin_mask = crash;
        end
      end
      PENDING: begin
        if (|on_pend) begin
          fin      = 1'b1;
          fin_mask = pend_grp_q | alive_q;
        end else if (|crash) begin
          fin      = 1'b1;
          fin_mask = pend_grp_q;
        end else if (|passed) begin
          fin      = 1'b1;
          fin_mask = alive_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      alive_q     <= '1;
      score_q     <= '0;
      prev_q      <= '1;
      pend_vld_q  <= 1'b0;
      pend_tube_q <= '0;
      pend_grp_q  <= '0;
      game_over_q <= 1'b0;
      win_vld_q   <= 1'b0;
      win_mask_q  <= '0;
    end else if (game_rst_i) begin
      state_q     <= RUN;
      alive_q     <= '1;
      score_q     <= '0;
      prev_q      <= tube_x_i;
      pend_vld_q  <= 1'b0;
      pend_tube_q <= '0;
      pend_grp_q  <= '0;
      game_over_q <= 1'b0;
      win_vld_q   <= 1'b0;
      win_mask_q  <= '0;
    end else begin
      win_vld_q <= 1'b0;
      if (tick_i && state_q != OVER) begin
        alive_q <= alive_d;
        score_q <= score_d;
        prev_q  <= tube_x_i;
        if (load_pend) begin
          pend_vld_q  <= 1'b1;
          pend_tube_q <= new_tube;
          pend_grp_q  <= new_grp;
        end
        if (to_pend) state_q <= PENDING;
        if (fin) begin
          state_q     <= OVER;
          game_over_q <= 1'b1;
          win_vld_q   <= 1'b1;
          win_mask_q  <= fin_mask;
        end
      end
    end
  end

  assign alive_o        = alive_q;
  assign score_o        = score_q;
  assign game_over_o    = game_over_q;
  assign winner_valid_o = win_vld_q;
  assign winner_mask_o  = win_mask_q;

endmodule

// File: tb/tb_race_referee.sv
// Bench for race_referee (4 birds, 3 tubes): directed round scenarios, a score-saturation sweep
// and randomized play, all checked against an integer reference model of the referee rules.
module tb_race_referee;

  logic             clk = 1'b0;
  logic             rst, game_rst, tick;
  logic [3:0][10:0] bird_y;
  logic [3:0]       bird_edge;
  logic [2:0][10:0] tube_x, gap_y;
  logic [3:0]       alive, winner_mask;
  logic [3:0][7:0]  score;
  logic             game_over, winner_valid;

  race_referee #(.N_BIRDS(4), .N_TUBES(3)) dut (
    .clk(clk), .rst(rst), .game_rst_i(game_rst), .tick_i(tick),
    .bird_y_i(bird_y), .bird_edge_i(bird_edge), .tube_x_i(tube_x), .gap_y_i(gap_y),
    .alive_o(alive), .score_o(score), .game_over_o(game_over),
    .winner_valid_o(winner_valid), .winner_mask_o(winner_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  logic [3:0] m_alive, m_pg, m_win;
  int         m_score[4];
  int         m_prev[3];
  int         m_state, m_pt;
  bit         m_pv, m_wv, m_go;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(int b, output int ti);
    int bx, by, best, x, g;
    bx = 180 + 80 * b;
    by = int'(bird_y[b]);
    best = -1;
    for (int t = 0; t < 3; t++) begin
      x = int'(tube_x[t]);
      if (x < 1024 && x + 120 > bx && (best < 0 || x < int'(tube_x[best]))) best = t;
    end
    ti = best;
    if (best < 0) return 1'b0;
    x = int'(tube_x[best]);
    g = int'(gap_y[best]);
    return (bx + 39 >= x) && (bx <= x + 119) && (by < g || by + 49 > g + 250);
  endfunction

  task automatic m_reset(input bit hard);
    m_alive = 4'hF; m_pg = '0; m_win = '0;
    m_state = 0; m_pt = 0; m_pv = 0; m_wv = 0; m_go = 0;
    for (int b = 0; b < 4; b++) m_score[b] = 0;
    for (int t = 0; t < 3; t++) m_prev[t] = hard ? 2047 : int'(tube_x[t]);
  endtask

  task automatic m_over(input logic [3:0] m);
    m_state = 2; m_go = 1; m_wv = 1; m_win = m;
  endtask

  task automatic m_tick();
    logic [3:0] cr, tc, na, grp;
    int ti[4];
    int s, bx, pt, sv;
    bit h, inc, anytc;
    for (int b = 0; b < 4; b++) begin
      h = m_hit(b, ti[b]);
      tc[b] = m_alive[b] & h;
      cr[b] = m_alive[b] & (bird_edge[b] | h);
    end
    na = m_alive & ~cr;
    s = $countones(na);
    for (int b = 0; b < 4; b++) begin
      bx = 180 + 80 * b;
      inc = 0;
      for (int t = 0; t < 3; t++)
        if (m_prev[t] < 1024 && m_prev[t] + 120 > bx && int'(tube_x[t]) + 120 <= bx) inc = 1;
      if (na[b] && inc && m_score[b] < 255) m_score[b]++;
    end
    for (int t = 0; t < 3; t++) m_prev[t] = int'(tube_x[t]);
    anytc = (tc != 0);
    pt = 0;
    for (int b = 3; b >= 0; b--) if (tc[b]) pt = ti[b];
    for (int b = 0; b < 4; b++) grp[b] = tc[b] && (ti[b] == pt);
    if (m_state == 0 && cr != 0) begin
      if (s >= 1 && anytc) begin m_pv = 1; m_pt = pt; m_pg = grp; end
      if (s == 1) begin
        if (anytc || m_pv) m_state = 1;
        else m_over(na);
      end else if (s == 0) m_over(cr);
    end else if (m_state == 1) begin
      sv = 0;
      for (int b = 0; b < 4; b++) if (m_alive[b]) sv = b;
      if (tc[sv] && ti[sv] == m_pt) m_over(m_pg | m_alive);
      else if (cr[sv]) m_over(m_pg);
      else if (180 + 80 * sv >= int'(tube_x[m_pt]) + 120 || int'(tube_x[m_pt]) >= 1024) m_over(m_alive);
    end
    m_alive = na;
  endtask

  task automatic check_all();
    chk("alive", alive, m_alive);
    for (int b = 0; b < 4; b++) chk($sformatf("score%0d", b), score[b], m_score[b]);
    chk("game_over", game_over, m_go);
    chk("winner_valid", winner_valid, m_wv);
    chk("winner_mask", winner_mask, m_win);
  endtask

  task automatic cyc(input bit t, input bit g);
    tick = t; game_rst = g;
    @(posedge clk);
    m_wv = 0;
    if (g) m_reset(0);
    else if (t && m_state != 2) m_tick();
    #1;
    tick = 0; game_rst = 0;
    check_all();
  endtask

  task automatic tubes_off();
    tube_x = {11'd1100, 11'd1100, 11'd1100};
    gap_y  = {11'd0, 11'd0, 11'd0};
  endtask

  // Bird0 dies on tube 0, birds 2/3 on the edge: bird1 is the lone survivor beside tube 0.
  task automatic pend_setup();
    tube_x    = {11'd1100, 11'd1100, 11'd150};
    gap_y     = {11'd0, 11'd0, 11'd300};
    bird_y    = {11'd350, 11'd350, 11'd350, 11'd0};
    bird_edge = 4'b0000;
    cyc(0, 1);
    bird_edge = 4'b1100;
    cyc(1, 0);
    bird_edge = 4'b0000;
    chk("pend_alive", alive, 4'b0010);
    chk("pend_no_over", game_over, 1'b0);
  endtask

  task automatic rand_inputs();
    int x, ti;
    for (int t = 0; t < 3; t++) begin
      x = int'(tube_x[t]);
      if (x >= 1024) x = 880 + int'($urandom_range(0, 140));
      else if (x < 24) begin
        x = 1100;
        gap_y[t] = 11'($urandom_range(0, 700));
      end else x = x - int'($urandom_range(0, 24));
      tube_x[t] = 11'(x);
    end
    for (int b = 0; b < 4; b++) begin
      void'(m_hit(b, ti));
      if (ti >= 0 && $urandom_range(0, 9) != 0)
        bird_y[b] = 11'(int'(gap_y[ti]) + int'($urandom_range(0, 200)));
      else bird_y[b] = 11'($urandom_range(0, 900));
      bird_edge[b] = ($urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    bit t, g;
    rst = 1'b1; tick = 0; game_rst = 0;
    bird_y = '0; bird_edge = '0;
    tubes_off();
    repeat (2) @(posedge clk);
    m_reset(1);
    #1 check_all();
    chk("rst_alive", alive, 4'hF);
    chk("rst_mask", winner_mask, 4'h0);
    @(negedge clk) rst = 1'b0;

    // lone edge survivor
    tubes_off();
    bird_y = {4{11'd350}};
    bird_edge = 4'b1110;
    cyc(0, 1);
    cyc(1, 0);
    chk("edge_alive", alive, 4'b0001);
    chk("edge_wv", winner_valid, 1'b1);
    chk("edge_mask", winner_mask, 4'b0001);
    cyc(0, 0);
    chk("edge_wv_drop", winner_valid, 1'b0);
    chk("edge_over_lvl", game_over, 1'b1);
    bird_edge = 4'b0001;
    cyc(1, 0);
    chk("over_hold", alive, 4'b0001);

    // same-tube draw
    pend_setup();
    bird_y[1] = 11'd0;
    cyc(1, 0);
    chk("draw_mask", winner_mask, 4'b0011);
    chk("draw_wv", winner_valid, 1'b1);

    // survivor clears the pending tube (bx 260 >= 140+120)
    pend_setup();
    bird_y[1] = 11'd350;
    tube_x[0] = 11'd140;
    cyc(1, 0);
    chk("pass_mask", winner_mask, 4'b0010);

    // two-stage wipe-out: last simultaneous crashers share the win
    tubes_off();
    bird_y = {4{11'd350}};
    cyc(0, 1);
    bird_edge = 4'b0101;
    cyc(1, 0);
    chk("wipe_run", game_over, 1'b0);
    bird_edge = 4'b1010;
    cyc(1, 0);
    chk("wipe_mask", winner_mask, 4'b1010);
    bird_edge = 4'b0000;

    // game_rst beats a simultaneous tick in PENDING
    pend_setup();
    bird_y[1] = 11'd0;
    cyc(1, 1);
    chk("grst_alive", alive, 4'hF);
    chk("grst_over", game_over, 1'b0);
    chk("grst_wv", winner_valid, 1'b0);

    // trailing edge crosses bird1; a respawn jump never scores
    tube_x = {11'd1100, 11'd1100, 11'd200};
    gap_y  = {11'd0, 11'd0, 11'd300};
    bird_y = {4{11'd350}};
    cyc(0, 1);
    tube_x[0] = 11'd140;
    cyc(1, 0);
    chk("score1_up", score[1], 8'd1);
    chk("score0_flat", score[0], 8'd0);
    tube_x[0] = 11'd1100;
    cyc(1, 0);
    chk("respawn_flat", score[0], 8'd0);

    // asynchronous rst mid-game
    pend_setup();
    rst = 1'b1;
    #2;
    chk("arst_alive", alive, 4'hF);
    chk("arst_score1", score[1], 8'd0);
    chk("arst_over", game_over, 1'b0);
    m_reset(1);
    check_all();
    @(negedge clk) rst = 1'b0;

    // saturation sweep: three staggered tubes, every bird parked in the gap
    tube_x = {11'd320, 11'd660, 11'd1000};
    gap_y  = {3{11'd300}};
    bird_y = {4{11'd350}};
    bird_edge = '0;
    cyc(0, 1);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (tube_x[k] >= 11'd1024) tube_x[k] = 11'd1000;
        else if (tube_x[k] < 11'd40) tube_x[k] = 11'd1100;
        else tube_x[k] = tube_x[k] - 11'd40;
      end
      cyc(1, 0);
    end
    for (int b = 0; b < 4; b++) chk($sformatf("sat%0d", b), score[b], 8'd255);

    // randomized play
    tube_x = {11'd320, 11'd660, 11'd1000};
    cyc(0, 1);
    for (int i = 0; i < 2500; i++) begin
      t = ($urandom_range(0, 3) != 0);
      g = m_go ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
      if (t) rand_inputs();
      cyc(t, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
